serial_engine_scheduler: RTL and testbench
==========================================

Name: serial_engine_scheduler

Overview:
- Round-robin scheduler that shares one external serial Moore engine (idle/s0/s1 toggle FSM, dout=1 in s1) between N_REQ parallel-word requesters.
- Per job: grants one requester and latches its word, then resets and wakes the engine.
- Shifts the word into the engine LSB-first and captures the engine output as the job result, i.e. the odd parity of the word.
- Sits between requester blocks and the engine instance; it is the engine's only driver.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- W, 8, word width in bits shifted per job (1..32).
- IDW, $clog2(N_REQ), width of requester id (derived localparam).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request, level; held until its gnt bit pulses.
- req_data  input  N_REQ*W  flattened words; requester i owns bits [i*W +: W]; stable while req[i]=1.
- gnt  output  N_REQ  one-hot, one-cycle pulse; word latched, requester may drop req/change data.
- eng_rst  output  1  synchronous reset to engine.
- eng_din  output  1  serial bit to engine.
- eng_dout  input  1  engine Moore output.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse, result valid.
- done_id  output  IDW  requester served; valid with done.
- result  output  1  captured eng_dout; valid with done.

Behaviour:
- Reset (async, any state): state=IDLE, rr pointer=N_REQ-1 (requester 0 highest priority first), gnt=0, done=0, done_id=0, result=0, eng_din=0, busy=0, data/shift regs=0.
- eng_rst = rst OR (state==ERST), so the engine is held reset throughout rst.
- States: IDLE -> ERST -> WAKE -> SHIFT -> DONE -> IDLE.
- IDLE: if any req bit is high at a clock edge:
  - select first set bit searching from pointer+1 modulo N_REQ;
  - latch its word and id; update pointer to the selected index; go to ERST.
  - No req: stay in IDLE.
- ERST (1 cycle): gnt[id]=1 (registered, exactly this cycle); eng_rst=1; eng_din=0.
- WAKE (1 cycle): eng_rst=0, eng_din=0; engine moves idle->s0 at the closing edge.
- SHIFT (exactly W cycles, bit counter 0..W-1): eng_din = word[counter] (LSB first); after counter=W-1 go to DONE.
- DONE (1 cycle): done=1, done_id=latched id, result=eng_dout sampled this cycle (engine now reflects all W bits); eng_din=0. Next state IDLE.
- result, done_id hold their values until the next DONE; done is low elsewhere.
- Latency: done is high in the (W+3)th cycle after the sampling edge in IDLE. Minimum job period W+4 cycles; IDLE always lasts at least 1 cycle.
- Requests arriving while busy wait; arbitration occurs only in IDLE.
- A requester whose req stays high after gnt is treated as a new request.
- Request dropped before grant: no job, no gnt.
- Simultaneous requests: strict round-robin fairness; with all N_REQ requesting continuously, each is served once per N_REQ jobs.
- Counter width $clog2(W)+1; no wrap beyond W-1.
- Reset mid-job: job aborted, no done, no gnt re-issued; requester must keep req asserted to be retried after reset (its earlier gnt, if already pulsed, is lost to the requester).

Optional Feature:
- Macro SCHED_PARITY_CHECK_EN.
- Defined:
  - adds output err (1 bit, reset 0);
  - in DONE, err=1 iff eng_dout != ^latched word, otherwise 0;
  - err is valid with done and holds until the next DONE.
- Undefined: no err port and no checker logic; all other behaviour is identical.

Test Plan:
- Reset then req=4'b0001, word0=8'hB5 -> gnt=4'b0001 one cycle; done high 11 cycles after the sampling edge; done_id=0, result=1.
- req[2] alone with word2=8'h3C -> result=0, done_id=2; eng_din sequence over SHIFT = 0,0,1,1,1,1,0,0.
- req=4'b1111 held (each dropped on its gnt), words 8'h01,8'h03,8'h07,8'h00 -> gnt order 0,1,2,3; results 1,0,1,0; done spacing 12 cycles.
- req[1] repeatedly re-asserted with req[3] pending -> grants alternate 3,1,3,1; busy low exactly one cycle between jobs.
- Assert rst for 1 cycle during SHIFT (counter=4) -> all outputs 0 immediately, eng_rst=1 during rst, no done; after release, pending req=4'b0001 is served first.
- SCHED_PARITY_CHECK_EN defined, engine model eng_dout stuck at 0, word 8'h01 -> result=0, err=1; word 8'h00 -> err=0.

Source files
------------

// File: rtl/serial_engine_scheduler_if.sv
// Requester, status and engine-side signals of the serial engine scheduler.
// err exists only when SCHED_PARITY_CHECK_EN is defined.
interface serial_engine_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   gnt;
  logic               eng_rst;
  logic               eng_din;
  logic               eng_dout;
  logic               busy;
  logic               done;
  logic [IDW-1:0]     done_id;
  logic               result;
`ifdef SCHED_PARITY_CHECK_EN
  logic               err;
`endif

  modport slave (
    input  req, req_data, eng_dout,
    output gnt, eng_rst, eng_din, busy, done, done_id, result
`ifdef SCHED_PARITY_CHECK_EN
    , output err
`endif
  );

  modport master (
    output req, req_data, eng_dout,
    input  gnt, eng_rst, eng_din, busy, done, done_id, result
`ifdef SCHED_PARITY_CHECK_EN
    , input err
`endif
  );
endinterface

// File: rtl/serial_engine_scheduler.sv
// Round-robin sharing of one serial parity engine; done W+3 cycles after the IDLE grant edge,
// requests wait while busy. SCHED_PARITY_CHECK_EN adds the err parity cross-check.
module serial_engine_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_engine_scheduler_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(W) + 1;

  typedef enum logic [2:0] {IDLE, ERST, WAKE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [W-1:0]     word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             result_q, result_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
`ifdef SCHED_PARITY_CHECK_EN
  logic             err_q, err_d;
`endif
  logic [IDW:0]     pick;
  logic [W-1:0]     word_sh;

  // Search starts just after the last served requester; scanning downwards lets
  // the nearest set bit overwrite farther ones.
  function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDW-1:0] p);
    logic [IDW:0] res;
    int j;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(p) + k) % N_REQ;
      if (r[IDW'(j)]) res = {1'b1, IDW'(j)};
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(N_REQ - 1);
      id_q      <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      result_q  <= 1'b0;
      done_id_q <= '0;
`ifdef SCHED_PARITY_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
`ifdef SCHED_PARITY_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    result_d  = result_q;
    done_id_d = done_id_q;
`ifdef SCHED_PARITY_CHECK_EN
    err_d     = err_q;
`endif
    pick      = rr_pick(bus.req, ptr_q);
    case (state_q)
      IDLE: if (pick[IDW]) begin
        state_d = ERST;
        ptr_d   = pick[IDW-1:0];
        id_d    = pick[IDW-1:0];
        word_d  = W'(bus.req_data >> (int'(pick[IDW-1:0]) * W));
        gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick[IDW-1:0];
      end
      ERST:  state_d = WAKE;
      WAKE: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        if (cnt_q == CW'(W - 1)) state_d = DONE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        state_d   = IDLE;
        result_d  = bus.eng_dout;
        done_id_d = id_q;
`ifdef SCHED_PARITY_CHECK_EN
        err_d     = bus.eng_dout != ^word_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // result/done_id are live in DONE and held from the capture flops afterwards.
  always_comb begin
    word_sh      = word_q >> cnt_q;
    bus.gnt      = gnt_q;
    bus.busy     = state_q != IDLE;
    bus.eng_rst  = rst | (state_q == ERST);
    bus.eng_din  = (state_q == SHIFT) & word_sh[0];
    bus.done     = state_q == DONE;
    bus.result   = (state_q == DONE) ? bus.eng_dout : result_q;
    bus.done_id  = (state_q == DONE) ? id_q : done_id_q;
`ifdef SCHED_PARITY_CHECK_EN
    bus.err      = (state_q == DONE) ? (bus.eng_dout != ^word_q) : err_q;
`endif
  end
endmodule

// File: tb/tb_serial_engine_scheduler.sv
// Bench for serial_engine_scheduler: engine model, grant/result scoreboard, vector table.
module tb_serial_engine_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int         id;
    logic [7:0] word;
    logic       res;
    logic       err;
  } exp_t;

  typedef struct {
    int         id;
    logic [7:0] word;
    logic       res;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic eng_stuck;
  logic [1:0] eng_st;

  serial_engine_scheduler_if #(.N_REQ(N), .W(W)) bus();
  serial_engine_scheduler #(.N_REQ(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // External engine: idle -> s0 on wake, toggles s0/s1 on din=1, dout=1 in s1.
  always @(posedge clk) begin
    if (bus.eng_rst) eng_st <= 2'd0;
    else case (eng_st)
      2'd0:    eng_st <= 2'd1;
      2'd1:    if (bus.eng_din) eng_st <= 2'd2;
      2'd2:    if (bus.eng_din) eng_st <= 2'd1;
      default: eng_st <= 2'd0;
    endcase
  end
  assign bus.eng_dout = (eng_st == 2'd2) && !eng_stuck;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int jobs_done = 0;
  bit active = 0;
  bit have_last = 0;
  bit done_now = 0;
  logic last_res;
  int last_id;
  logic [W-1:0] din_cap;
  exp_t cur;
  exp_t exp_q[$];
  int rem[N];
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic set_word(input int id, input logic [7:0] w);
    bus.req_data = (bus.req_data & ~(32'hFF << (id * 8))) | (32'(w) << (id * 8));
  endtask

  // One cycle: advance to the falling edge and score whatever the DUT shows.
  task automatic tick();
    logic [3:0] one;
    one = 4'b0001;
    @(negedge clk);
    cyc++;
    done_now = 0;
    if (rst) begin
      active = 0;
      have_last = 0;
    end else begin
      if (bus.gnt != '0) begin
        if (exp_q.size() == 0) chk("gnt_unexpected", 32'(bus.gnt), 32'(0));
        else begin
          cur = exp_q.pop_front();
          chk("gnt", 32'(bus.gnt), 32'(one << cur.id));
          chk("eng_rst_erst", 32'(bus.eng_rst), 32'(1));
          active = 1;
          gnt_cyc = cyc;
        end
      end else if (active && cyc == gnt_cyc + 1) begin
        chk("eng_rst_wake", 32'(bus.eng_rst), 32'(0));
      end
      if (active && cyc >= gnt_cyc + 2 && cyc <= gnt_cyc + W + 1)
        din_cap[3'(cyc - gnt_cyc - 2)] = bus.eng_din;
      if (bus.done) begin
        if (!active) chk("done_unexpected", 32'(bus.done), 32'(0));
        else begin
          chk("done_id", 32'(bus.done_id), 32'(cur.id));
          chk("result", 32'(bus.result), 32'(cur.res));
          chk("latency", 32'(cyc - gnt_cyc), 32'(W + 2));
          chk("din_seq", 32'(din_cap), 32'(cur.word));
`ifdef SCHED_PARITY_CHECK_EN
          chk("err", 32'(bus.err), 32'(cur.err));
`endif
          active = 0;
          jobs_done++;
          done_now = 1;
          last_res = cur.res;
          last_id = cur.id;
          have_last = 1;
        end
      end else if (have_last) begin
        chk("result_hold", 32'(bus.result), 32'(last_res));
        chk("done_id_hold", 32'(bus.done_id), 32'(last_id));
      end
    end
  endtask

  // Requesters raise req while rem[i] > 0, keep it up across grants until rem hits 0.
  task automatic run_jobs(input int total, input bit chk_gap, input bit chk_spacing);
    int start, guard, gap, last_dc;
    bit prev_busy, seen_busy;
    start = jobs_done;
    guard = 0;
    gap = 0;
    last_dc = -1;
    prev_busy = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < N; i++) bus.req[2'(i)] = rem[i] > 0;
    while (jobs_done - start < total && guard < 3000) begin
      tick();
      guard++;
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[2'(i)] && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) bus.req[2'(i)] = 1'b0;
        end
      end
      if (chk_gap) begin
        if (!bus.busy) gap++;
        else begin
          if (!prev_busy && seen_busy) chk("busy_gap", 32'(gap), 32'(1));
          gap = 0;
          seen_busy = 1'b1;
        end
        prev_busy = bus.busy;
      end
      if (done_now && chk_spacing) begin
        if (last_dc >= 0) chk("done_spacing", 32'(cyc - last_dc), 32'(W + 4));
        last_dc = cyc;
      end
    end
    if (guard >= 3000) chk("run_jobs_timeout", 32'(jobs_done - start), 32'(total));
  endtask

  initial begin
    int guard;
    tbl[0] = '{0, 8'hB5, 1'b1};
    tbl[1] = '{1, 8'hFF, 1'b0};
    tbl[2] = '{3, 8'h80, 1'b1};
    tbl[3] = '{0, 8'h00, 1'b0};
    tbl[4] = '{3, 8'h7F, 1'b1};
    tbl[5] = '{2, 8'h3C, 1'b0};
    for (int i = 0; i < N; i++) rem[i] = 0;

    rst = 1'b1;
    eng_stuck = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(bus.gnt), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_done_id", 32'(bus.done_id), 32'(0));
    chk("rst_result", 32'(bus.result), 32'(0));
    chk("rst_eng_din", 32'(bus.eng_din), 32'(0));
    chk("rst_eng_rst", 32'(bus.eng_rst), 32'(1));
    rst = 1'b0;
    tick();

    // All four requesting together from reset: served 0,1,2,3 back to back.
    set_word(0, 8'h01); set_word(1, 8'h03); set_word(2, 8'h07); set_word(3, 8'h00);
    exp_q.push_back('{0, 8'h01, 1'b1, 1'b0});
    exp_q.push_back('{1, 8'h03, 1'b0, 1'b0});
    exp_q.push_back('{2, 8'h07, 1'b1, 1'b0});
    exp_q.push_back('{3, 8'h00, 1'b0, 1'b0});
    for (int i = 0; i < N; i++) rem[i] = 1;
    run_jobs(4, 1'b1, 1'b1);

    for (int v = 0; v < 6; v++) begin
      set_word(tbl[v].id, tbl[v].word);
      exp_q.push_back('{tbl[v].id, tbl[v].word, tbl[v].res, 1'b0});
      rem[tbl[v].id] = 1;
      run_jobs(1, 1'b0, 1'b0);
      repeat (2) tick();
    end

    // Pointer now at 2: requesters 3 and 1 alternate while both keep asking.
    set_word(1, 8'h01); set_word(3, 8'h0F);
    exp_q.push_back('{3, 8'h0F, 1'b0, 1'b0});
    exp_q.push_back('{1, 8'h01, 1'b1, 1'b0});
    exp_q.push_back('{3, 8'h0F, 1'b0, 1'b0});
    exp_q.push_back('{1, 8'h01, 1'b1, 1'b0});
    rem[1] = 2;
    rem[3] = 2;
    run_jobs(4, 1'b1, 1'b0);
    repeat (2) tick();

    // Reset in the middle of SHIFT (bit 4): job dropped, requester 0 served afterwards.
    set_word(2, 8'hA5);
    exp_q.push_back('{2, 8'hA5, 1'b0, 1'b0});
    bus.req[2] = 1'b1;
    guard = 0;
    while (!active && guard < 100) begin tick(); guard++; end
    bus.req[2] = 1'b0;
    if (guard >= 100) chk("rst_test_gnt_timeout", 32'(active), 32'(1));
    while (cyc < gnt_cyc + 6 && guard < 200) begin tick(); guard++; end
    set_word(0, 8'h01);
    bus.req[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(bus.gnt), 32'(0));
    chk("midrst_busy", 32'(bus.busy), 32'(0));
    chk("midrst_done", 32'(bus.done), 32'(0));
    chk("midrst_eng_din", 32'(bus.eng_din), 32'(0));
    chk("midrst_eng_rst", 32'(bus.eng_rst), 32'(1));
    chk("midrst_result", 32'(bus.result), 32'(0));
    chk("midrst_done_id", 32'(bus.done_id), 32'(0));
    tick();
    chk("midrst_eng_rst_held", 32'(bus.eng_rst), 32'(1));
    rst = 1'b0;
    exp_q.push_back('{0, 8'h01, 1'b1, 1'b0});
    rem[0] = 1;
    run_jobs(1, 1'b0, 1'b0);
    repeat (2) tick();

`ifdef SCHED_PARITY_CHECK_EN
    eng_stuck = 1'b1;
    set_word(0, 8'h01);
    exp_q.push_back('{0, 8'h01, 1'b0, 1'b1});
    rem[0] = 1;
    run_jobs(1, 1'b0, 1'b0);
    repeat (2) tick();
    set_word(0, 8'h00);
    exp_q.push_back('{0, 8'h00, 1'b0, 1'b0});
    rem[0] = 1;
    run_jobs(1, 1'b0, 1'b0);
    repeat (2) tick();
    eng_stuck = 1'b0;
`endif

    chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
